// File: rtl/vga_copper_pkg.sv
// vga_copper_pkg: shared register offsets, FSM encoding and strobe constants for the VGA copper.
package vga_copper_pkg;
  localparam logic [5:0] ENTRY_BASE  = 6'h00;
  localparam logic [5:0] CTRL_ADDR   = 6'h20;
  localparam logic [5:0] STATUS_ADDR = 6'h24;
  localparam int LINE_LSB  = 16;
  localparam int VADDR_LSB = 0;
  localparam logic [1:0] WR_NONE = 2'b11;
  localparam logic [1:0] WR_32   = 2'b10;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_ISSUE = 2'd2, ST_DONE = 2'd3} state_t;
endpackage

// File: rtl/vga_copper_arb.sv
// vga_copper_arb: 2:1 priority mux onto the VGA register write port; CPU always wins.
module vga_copper_arb
  import vga_copper_pkg::*;
(
  input  logic        i_cop_req,
  input  logic [5:0]  i_cop_address,
  input  logic [31:0] i_cop_data,
  input  logic [5:0]  i_cpu_address,
  input  logic [31:0] i_cpu_data,
  input  logic [1:0]  i_cpu_write_n,
  output logic [5:0]  o_address,
  output logic [31:0] o_data,
  output logic [1:0]  o_write_n,
  output logic        o_grant_copper
);
  assign o_grant_copper = i_cop_req && i_cpu_write_n == WR_NONE;
  assign o_address      = o_grant_copper ? i_cop_address : i_cpu_address;
  assign o_data         = o_grant_copper ? i_cop_data : i_cpu_data;
  assign o_write_n      = o_grant_copper ? WR_32 : i_cpu_write_n;
endmodule

// File: rtl/tqvp_rejunity_vga_copper.sv
// tqvp_rejunity_vga_copper: raster-synchronised VGA register sequencer with CPU-priority write arbitration.
// Define COPPER_IRQ_EN to enable the list-done interrupt and its CTRL[1] mask.
module tqvp_rejunity_vga_copper
  import vga_copper_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int LINE_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        address,
  input  logic [31:0]       data_in,
  input  logic [1:0]        data_write_n,
  input  logic [1:0]        data_read_n,
  output logic [31:0]       data_out,
  output logic              data_ready,
  input  logic [LINE_W-1:0] vga_y,
  input  logic              vga_new_scanline,
  input  logic [5:0]        cpu_vga_address,
  input  logic [31:0]       cpu_vga_data,
  input  logic [1:0]        cpu_vga_write_n,
  output logic [5:0]        m_address,
  output logic [31:0]       m_data,
  output logic [1:0]        m_write_n,
  output logic              copper_irq
);
  logic [LINE_W-1:0] r_line [ENTRIES];
  logic [5:0]        r_vaddr [ENTRIES];
  logic [31:0]       r_data [ENTRIES];
  logic              r_en;
  logic [2:0]        r_cnt;
  logic [2:0]        r_idx;
  state_t            r_state;
  logic              w_wr32, w_ctrl_wr, w_en_next, w_mask, w_req, w_grant, w_pending;
  logic              w_hit_cur, w_hit_nxt, w_done_next;
  logic [2:0]        w_cnt_wr, w_idx_nxt;
  logic [LINE_W-1:0] w_line_cur, w_line_nxt;
  logic [5:0]        w_vaddr, w_cpu_address;
  logic [31:0]       w_data, w_cpu_data;
  logic [1:0]        w_cpu_write_n;
`ifdef COPPER_IRQ_EN
  logic              r_mask, r_irq;
  assign w_mask     = r_mask;
  assign copper_irq = r_irq & r_mask;
`else
  assign w_mask     = 1'b0;
  assign copper_irq = 1'b0;
`endif
  assign data_ready = 1'b1;
  assign w_wr32     = data_write_n == WR_32;
  assign w_ctrl_wr  = w_wr32 && address == CTRL_ADDR;
  assign w_en_next  = w_ctrl_wr ? data_in[0] : r_en;
  assign w_cnt_wr   = data_in[11:8] > 4'(ENTRIES) ? 3'(ENTRIES) : data_in[10:8];
  assign w_idx_nxt  = r_idx + 3'd1;
  always_comb begin
    w_line_cur = '0;
    w_line_nxt = '0;
    w_vaddr    = '0;
    w_data     = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_line_cur = r_idx == 3'(i) ? r_line[i] : w_line_cur;
      w_vaddr    = r_idx == 3'(i) ? r_vaddr[i] : w_vaddr;
      w_data     = r_idx == 3'(i) ? r_data[i] : w_data;
      w_line_nxt = w_idx_nxt == 3'(i) ? r_line[i] : w_line_nxt;
    end
  end
  assign w_hit_cur   = r_idx < r_cnt && vga_y >= w_line_cur;
  assign w_hit_nxt   = w_idx_nxt < r_cnt && vga_y >= w_line_nxt;
  assign w_done_next = !w_hit_nxt && w_idx_nxt >= r_cnt;
  assign w_req       = r_state == ST_ISSUE;
  assign w_pending   = w_req && !w_grant;
  // Entry RAM deliberately has no reset.
  always_ff @(posedge clk)
    for (int i = 0; i < ENTRIES; i++)
      if (w_wr32 && address[5:3] == 3'(i)) begin
        if (address[2]) r_data[i] <= data_in;
        else begin
          r_line[i]  <= data_in[LINE_LSB +: LINE_W];
          r_vaddr[i] <= data_in[VADDR_LSB +: 6];
        end
      end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_en  <= 1'b0;
      r_cnt <= '0;
`ifdef COPPER_IRQ_EN
      r_mask <= 1'b0;
`endif
    end else if (w_ctrl_wr) begin
      r_en  <= data_in[0];
      r_cnt <= w_cnt_wr;
`ifdef COPPER_IRQ_EN
      r_mask <= data_in[1];
`endif
    end
  // Disable takes effect on the CTRL write itself so a held write is dropped at once.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
`ifdef COPPER_IRQ_EN
      r_irq   <= 1'b0;
`endif
    end else begin
`ifdef COPPER_IRQ_EN
      if (w_ctrl_wr) r_irq <= 1'b0;
      if (w_en_next && r_state == ST_ISSUE && w_grant && w_done_next &&
          !(vga_new_scanline && vga_y == '0)) r_irq <= 1'b1;
`endif
      if (!w_en_next) begin
        r_state <= ST_IDLE;
        r_idx   <= '0;
      end else if (r_state == ST_IDLE) begin
        r_state <= ST_WAIT;
        r_idx   <= '0;
      end else if (vga_new_scanline && vga_y == '0) begin
        r_idx   <= '0;
        r_state <= r_cnt != '0 && r_line[0] == '0 ? ST_ISSUE : ST_WAIT;
      end else if (r_state == ST_WAIT) begin
        if (vga_new_scanline && w_hit_cur) r_state <= ST_ISSUE;
      end else if (r_state == ST_ISSUE && w_grant) begin
        r_idx   <= w_idx_nxt;
        r_state <= w_hit_nxt ? ST_ISSUE : w_done_next ? ST_DONE : ST_WAIT;
      end
    end
  always_comb begin
    data_out = '0;
    if (data_read_n != WR_NONE) begin
      data_out = address == CTRL_ADDR ? {20'b0, 1'b0, r_cnt, 6'b0, w_mask, r_en} : data_out;
      data_out = address == STATUS_ADDR ? {23'b0, w_pending, 2'b0, r_state, 1'b0, r_idx} : data_out;
      for (int i = 0; i < ENTRIES; i++)
        data_out = address[5:3] == 3'(i) ?
          (address[2] ? r_data[i] : (32'(r_line[i]) << LINE_LSB) | (32'(r_vaddr[i]) << VADDR_LSB)) : data_out;
    end
  end
  // Hold the write port idle while reset is asserted, independent of the CPU path.
  assign w_cpu_address = rst_n ? cpu_vga_address : '0;
  assign w_cpu_data    = rst_n ? cpu_vga_data : '0;
  assign w_cpu_write_n = rst_n ? cpu_vga_write_n : WR_NONE;
  vga_copper_arb u_arb (
    .i_cop_req      (w_req),
    .i_cop_address  (w_vaddr),
    .i_cop_data     (w_data),
    .i_cpu_address  (w_cpu_address),
    .i_cpu_data     (w_cpu_data),
    .i_cpu_write_n  (w_cpu_write_n),
    .o_address      (m_address),
    .o_data         (m_data),
    .o_write_n      (m_write_n),
    .o_grant_copper (w_grant)
  );
endmodule
